// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: merges priority ALU results and FIFO-buffered long-latency
// results onto the single register-file write port, and tracks pending destinations.
module reg_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_wen_i,
    input  logic [AW-1:0]     alu_waddr_i,
    input  logic [DW-1:0]     alu_wdata_i,
    input  logic              lsu_valid_i,
    input  logic [AW-1:0]     lsu_waddr_i,
    input  logic [DW-1:0]     lsu_wdata_i,
    output logic              lsu_ready_o,
    input  logic              issue_valid_i,
    input  logic [AW-1:0]     issue_rd_i,
    output logic [2**AW-1:0]  busy_o,
    output logic [AW-1:0]     reg_waddr_o,
    output logic [DW-1:0]     reg_wdata_o,
    output logic              reg_wen_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 2**AW;

    logic [AW-1:0]  memAddr_q [DEPTH];
    logic [DW-1:0]  memData_q [DEPTH];
    logic [PW-1:0]  wrPtr_q, wrPtr_d;
    logic [PW-1:0]  rdPtr_q, rdPtr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [NR-1:0]  busy_q, busy_d;
    logic           regWen_q, regWen_d;
    logic [AW-1:0]  regWaddr_q, regWaddr_d;
    logic [DW-1:0]  regWdata_q, regWdata_d;

    logic           aluWins;
    logic           fifoEmpty;
    logic           push;
    logic           pop;
    logic [AW-1:0]  headAddr;
    logic [DW-1:0]  headData;

    assign lsu_ready_o = (count_q < CW'(DEPTH)) && !rst;
    assign push        = lsu_valid_i && lsu_ready_o;
    assign aluWins     = alu_wen_i && (alu_waddr_i != '0);
    assign fifoEmpty   = (count_q == '0);
    // An ALU write to x0 does not occupy the port, so the FIFO may drain under it.
    assign pop         = !aluWins && !fifoEmpty;
    assign headAddr    = memAddr_q[rdPtr_q];
    assign headData    = memData_q[rdPtr_q];

    assign busy_o      = busy_q;
    assign reg_wen_o   = regWen_q;
    assign reg_waddr_o = regWaddr_q;
    assign reg_wdata_o = regWdata_q;

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        busy_d     = busy_q;
        regWen_d   = 1'b0;
        regWaddr_d = regWaddr_q;
        regWdata_d = regWdata_q;

        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (aluWins) begin
            regWen_d   = 1'b1;
            regWaddr_d = alu_waddr_i;
            regWdata_d = alu_wdata_i;
        end else if (pop) begin
            regWen_d   = (headAddr != '0);
            regWaddr_d = headAddr;
            regWdata_d = headData;
        end

        // Clear before set so a same-cycle re-issue of the popped register stays busy.
        if (pop && (headAddr != '0)) begin
            busy_d[headAddr] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            regWen_q   <= 1'b0;
            regWaddr_q <= '0;
            regWdata_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            regWen_q   <= regWen_d;
            regWaddr_q <= regWaddr_d;
            regWdata_q <= regWdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memAddr_q[wrPtr_q] <= lsu_waddr_i;
            memData_q[wrPtr_q] <= lsu_wdata_i;
        end
    end

endmodule
